// File: rtl/cv32e40p_tmr_pmp_scrubber.sv
// Triplicated PMP entry storage with a periodic/on-demand majority scrubber.
// Each copy drives one leg of the downstream TMR voter.
module cv32e40p_tmr_pmp_scrubber #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned N_PMP_ENTRIES = 16,
  parameter int unsigned SCRUB_PERIOD  = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        wr_en_i,
  input  logic [$clog2(N_PMP_ENTRIES)-1:0]            wr_idx_i,
  input  logic [WIDTH-1:0]                            wr_data_i,
  input  logic                                        scrub_req_i,
  input  logic                                        inj_en_i,
  input  logic [1:0]                                  inj_copy_i,
  input  logic [$clog2(N_PMP_ENTRIES)-1:0]            inj_idx_i,
  input  logic [WIDTH-1:0]                            inj_mask_i,
  output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]         copy1_o,
  output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]         copy2_o,
  output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]         copy3_o,
  output logic                                        busy_o,
  output logic                                        corr_o,
  output logic [CNT_W-1:0]                            corr_cnt_o,
  output logic                                        scan_done_o
);

  localparam int unsigned IDX_W = $clog2(N_PMP_ENTRIES);
  localparam int unsigned PER_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [N_PMP_ENTRIES-1:0][WIDTH-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] e0, e1, e2, maj;
  logic scan, mismatch, wr_hit, corr, auto_hit, last;

  always_comb begin
    e0       = c0_q[idx_q];
    e1       = c1_q[idx_q];
    e2       = c2_q[idx_q];
    maj      = (e0 & e1) | (e0 & e2) | (e1 & e2);
    scan     = (state_q == ST_SCAN);
    mismatch = (e0 != maj) || (e1 != maj) || (e2 != maj);
    // A software write to the entry being scanned wins over the correction.
    wr_hit   = wr_en_i && (wr_idx_i == idx_q);
    corr     = scan && mismatch && !wr_hit;
    last     = (idx_q == IDX_W'(N_PMP_ENTRIES - 1));
    auto_hit = (SCRUB_PERIOD != 0) && (per_q == PER_W'(SCRUB_PERIOD - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    per_d   = per_q;
    if (state_q == ST_IDLE) begin
      if (scrub_req_i || auto_hit) begin
        state_d = ST_SCAN;
        per_d   = '0;
      end else begin
        per_d = per_q + 1'b1;
      end
    end else if (last) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (corr && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Lowest priority first: injection, then correction, then software write.
  always_comb begin
    c0_d = c0_q;
    c1_d = c1_q;
    c2_d = c2_q;
    if (inj_en_i) begin
      case (inj_copy_i)
        2'd0:    c0_d[inj_idx_i] = c0_q[inj_idx_i] ^ inj_mask_i;
        2'd1:    c1_d[inj_idx_i] = c1_q[inj_idx_i] ^ inj_mask_i;
        2'd2:    c2_d[inj_idx_i] = c2_q[inj_idx_i] ^ inj_mask_i;
        default: ;
      endcase
    end
    if (corr) begin
      c0_d[idx_q] = maj;
      c1_d[idx_q] = maj;
      c2_d[idx_q] = maj;
    end
    if (wr_en_i) begin
      c0_d[wr_idx_i] = wr_data_i;
      c1_d[wr_idx_i] = wr_data_i;
      c2_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c0_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      per_q   <= '0;
      cnt_q   <= '0;
    end else begin
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
    end
  end

  assign copy1_o     = c0_q;
  assign copy2_o     = c1_q;
  assign copy3_o     = c2_q;
  assign busy_o      = scan;
  assign corr_o      = corr;
  assign corr_cnt_o  = cnt_q;
  assign scan_done_o = scan && last;

endmodule

// File: tb/tb_cv32e40p_tmr_pmp_scrubber.sv
// Directed bench for the TMR PMP scrubber: main instance with manual scans and a
// 2-bit counter, plus a second instance with an 8-cycle automatic scan period.
module tb_cv32e40p_tmr_pmp_scrubber;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [3:0] wr_idx = '0;
  logic [31:0] wr_data = '0;
  logic scrub_req = 1'b0;
  logic inj_en = 1'b0;
  logic [1:0] inj_copy = '0;
  logic [3:0] inj_idx = '0;
  logic [31:0] inj_mask = '0;

  logic [15:0][31:0] m_c1, m_c2, m_c3, p_c1, p_c2, p_c3;
  logic m_busy, m_corr, m_done, p_busy, p_corr, p_done;
  logic [1:0] m_cnt;
  logic [15:0] p_cnt;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cv32e40p_tmr_pmp_scrubber #(
    .WIDTH(32), .N_PMP_ENTRIES(16), .SCRUB_PERIOD(0), .CNT_W(2)
  ) u_main (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .scrub_req_i(scrub_req), .inj_en_i(inj_en), .inj_copy_i(inj_copy),
    .inj_idx_i(inj_idx), .inj_mask_i(inj_mask), .copy1_o(m_c1), .copy2_o(m_c2),
    .copy3_o(m_c3), .busy_o(m_busy), .corr_o(m_corr), .corr_cnt_o(m_cnt),
    .scan_done_o(m_done)
  );

  cv32e40p_tmr_pmp_scrubber #(
    .WIDTH(32), .N_PMP_ENTRIES(16), .SCRUB_PERIOD(8), .CNT_W(16)
  ) u_per (
    .clk(clk), .rst(rst), .wr_en_i(1'b0), .wr_idx_i(4'd0), .wr_data_i(32'd0),
    .scrub_req_i(1'b0), .inj_en_i(1'b0), .inj_copy_i(2'd0),
    .inj_idx_i(4'd0), .inj_mask_i(32'd0), .copy1_o(p_c1), .copy2_o(p_c2),
    .copy3_o(p_c3), .busy_o(p_busy), .corr_o(p_corr), .corr_cnt_o(p_cnt),
    .scan_done_o(p_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [31:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_inject(input logic [1:0] cp, input logic [3:0] idx, input logic [31:0] mask);
    inj_en = 1'b1; inj_copy = cp; inj_idx = idx; inj_mask = mask;
    tick();
    inj_en = 1'b0;
  endtask

  // Full scan with a single expected correction at fidx (-1: none).
  task automatic run_scan(input int fidx);
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("scan_busy", m_busy, 1'b1);
      chk("scan_corr", m_corr, (i == fidx));
      chk("scan_done", m_done, (i == 15));
      tick();
    end
    chk("scan_end_busy", m_busy, 1'b0);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_cnt", m_cnt, 2'd0);
    chk("rst_done", m_done, 1'b0);
    chk("rst_copy", m_c1[0], 32'h0);

    // Automatic scans: 8 idle cycles then 16 busy, period 24.
    for (int c = 0; c < 48; c++) begin
      chk("per_busy", p_busy, ((c % 24) >= 8));
      chk("per_corr", p_corr, 1'b0);
      chk("main_idle", m_busy, 1'b0);
      tick();
    end
    chk("per_cnt", p_cnt, 16'd0);

    do_write(4'd3, 32'hDEADBEEF);
    chk("wr_c1", m_c1[3], 32'hDEADBEEF);
    chk("wr_c2", m_c2[3], 32'hDEADBEEF);
    chk("wr_c3", m_c3[3], 32'hDEADBEEF);
    chk("wr_other", m_c1[2], 32'h0);
    chk("wr_busy", m_busy, 1'b0);

    do_write(4'd5, 32'h11111111);
    do_inject(2'd1, 4'd5, 32'h000000F0);
    chk("inj_c2", m_c2[5], 32'h111111E1);
    chk("inj_c1", m_c1[5], 32'h11111111);
    run_scan(5);
    chk("fix_c2", m_c2[5], 32'h11111111);
    chk("fix_cnt", m_cnt, 2'd1);

    // Write lands on the entry being scanned; a mid-scan request is dropped.
    do_inject(2'd0, 4'd9, 32'h000000FF);
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 9) begin
        wr_en = 1'b1; wr_idx = 4'd9; wr_data = 32'hCAFEF00D;
      end
      scrub_req = (i == 2);
      #1;
      chk("wscan_corr", m_corr, 1'b0);
      tick();
      wr_en = 1'b0;
      scrub_req = 1'b0;
    end
    chk("wscan_c1", m_c1[9], 32'hCAFEF00D);
    chk("wscan_c2", m_c2[9], 32'hCAFEF00D);
    chk("wscan_c3", m_c3[9], 32'hCAFEF00D);
    chk("wscan_cnt", m_cnt, 2'd1);
    chk("noqueue_busy", m_busy, 1'b0);
    tick();
    chk("noqueue_busy2", m_busy, 1'b0);

    do_inject(2'd3, 4'd1, 32'hFFFFFFFF);
    chk("inj3_c1", m_c1[1], 32'h0);
    chk("inj3_c2", m_c2[1], 32'h0);
    chk("inj3_c3", m_c3[1], 32'h0);

    // Disjoint faults in copies 0 and 2 of one entry: one correction.
    do_inject(2'd0, 4'd7, 32'h0000000F);
    do_inject(2'd2, 4'd7, 32'h00000F00);
    run_scan(7);
    chk("dual_c1", m_c1[7], 32'h0);
    chk("dual_c3", m_c3[7], 32'h0);
    chk("dual_cnt", m_cnt, 2'd2);

    do_inject(2'd1, 4'd12, 32'h00000001);
    run_scan(12);
    chk("sat_cnt3", m_cnt, 2'd3);
    do_inject(2'd1, 4'd12, 32'h00000001);
    run_scan(12);
    chk("sat_hold", m_cnt, 2'd3);
    chk("sat_c2", m_c2[12], 32'h0);

    // Reset four cycles into a scan with a pending fault.
    do_inject(2'd0, 4'd10, 32'h00000001);
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", m_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", m_busy, 1'b0);
    chk("mrst_c1_3", m_c1[3], 32'h0);
    chk("mrst_c1_10", m_c1[10], 32'h0);
    chk("mrst_c2_9", m_c2[9], 32'h0);
    chk("mrst_cnt", m_cnt, 2'd0);
    for (int i = 0; i < 20; i++) begin
      chk("mrst_done", m_done, 1'b0);
      chk("mrst_idle", m_busy, 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_pmp_scrubber.md
Name: cv32e40p_tmr_pmp_scrubber

Overview:
- Triplicated PMP entry storage that feeds res1/res2/res3 of the downstream 2D TMR voter.
- Holds three copies of N_PMP_ENTRIES x WIDTH registers and accepts software writes into all three copies.
- Periodically, or on request, walks every entry, computes the bitwise 2-of-3 majority, and rewrites divergent copies.
- Counts corrections; provides a fault-injection port for verification.

Parameters:
- WIDTH, 32, bits per PMP entry.
- N_PMP_ENTRIES, 16, number of entries; power of 2, >= 2.
- SCRUB_PERIOD, 1024, idle cycles between automatic scans; 0 disables automatic scans.
- CNT_W, 16, width of the correction counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en_i  in  1  software write strobe.
- wr_idx_i  in  $clog2(N_PMP_ENTRIES)  entry index for the write.
- wr_data_i  in  WIDTH  write data; goes to all three copies.
- scrub_req_i  in  1  single-cycle request to start a scan.
- inj_en_i  in  1  fault-injection strobe.
- inj_copy_i  in  2  target copy: 0, 1 or 2; 3 is ignored.
- inj_idx_i  in  $clog2(N_PMP_ENTRIES)  entry to corrupt.
- inj_mask_i  in  WIDTH  XOR mask applied to the target copy.
- copy1_o  out  [N_PMP_ENTRIES-1:0][WIDTH-1:0]  copy 0; to voter res1.
- copy2_o  out  same  copy 1; to voter res2.
- copy3_o  out  same  copy 2; to voter res3.
- busy_o  out  1  high while in SCAN.
- corr_o  out  1  one-cycle pulse when an entry is corrected.
- corr_cnt_o  out  CNT_W  saturating count of corrected entries.
- scan_done_o  out  1  one-cycle pulse after the last entry is scanned.

Behaviour:
- Reset (rst=1 at an edge):
  - all copies 0; FSM=IDLE; period counter 0; scan index 0.
  - busy_o=0, corr_o=0, scan_done_o=0, corr_cnt_o=0.
  - Reset mid-scan aborts the scan immediately; no partial correction is committed that cycle.
- Copy outputs are direct register outputs; no combinational path from any input.
- Write:
  - wr_en_i at an edge sets all three copies of wr_idx_i to wr_data_i.
  - Visible on the outputs the cycle after the strobe (1-cycle latency).
  - Accepted in any FSM state.
- Injection:
  - inj_en_i with inj_copy_i<3 XORs inj_mask_i into that copy/entry at the edge.
  - inj_copy_i=3 has no effect.
- FSM IDLE:
  - Period counter increments each cycle.
  - Enter SCAN on scrub_req_i, or when SCRUB_PERIOD!=0 and counter==SCRUB_PERIOD-1.
  - Counter clears on the transition.
  - scrub_req_i while in SCAN is ignored and not queued.
- FSM SCAN (busy_o=1):
  - One entry per cycle, starting at index 0.
  - maj = (c0&c1)|(c0&c2)|(c1&c2) on the current entry.
  - If any copy differs from maj: write maj into all three copies at that edge, pulse corr_o that same cycle, and increment corr_cnt_o (saturates at all-ones).
  - Index increments each cycle.
  - On index N_PMP_ENTRIES-1: pulse scan_done_o, return to IDLE, reset index to 0.
  - Full scan is exactly N_PMP_ENTRIES cycles.
- Same-entry, same-cycle priority, highest first:
  1. Software write: applies to all copies; suppresses the correction, corr_o and the count.
  2. Scrub correction: writes maj; a simultaneous injection to that entry is dropped.
  3. Injection.
- Different-entry simultaneous events all apply independently.
- Triple bitwise disagreement cannot occur (majority is always defined per bit). Multi-bit faults confined to one copy are fully corrected.
- Faults in the same bit of two copies correct to the wrong value; this is out of scope and not flagged.

Test Plan:
- Reset, then write idx 3 = 0xDEADBEEF -> next cycle all three copy outputs [3] = 0xDEADBEEF; other entries 0; busy_o=0.
- Inject copy 1, idx 5, mask 0x0000_00F0 after writing 0x11111111 -> copy2_o[5]=0x111111E1. Then scrub_req_i -> busy_o high 16 cycles; corr_o pulses at scan cycle 5 only; copy2_o[5]=0x11111111; corr_cnt_o=1; scan_done_o pulses on the 16th cycle.
- SCRUB_PERIOD=8, no requests -> busy_o rises after 8 idle cycles, lasts 16, repeats every 24 cycles; corr_cnt_o stays 0.
- During a scan, write idx k=wr_idx at the cycle the scan reaches k, with injected fault present -> entry equals written value, no corr_o, count unchanged.
- Inject different masks into copies 0 and 2 of idx 7 (disjoint bits), then scan -> both restored, corr_cnt_o +1. Set counter to all-ones via repeated scans (CNT_W=2: 4 corrections) -> corr_cnt_o holds 3.
- Assert rst at scan cycle 4 -> next cycle busy_o=0, all copies 0, corr_cnt_o=0, scan_done_o never pulses.
